// File: rtl/wb_regfile_sb_pkg.sv
// wb_pkg: shared widths, op-code classes and op decode helpers for the
// writeback / register-file / scoreboard slice.
//   DW        data width
//   NREG      register count, AW address width
//   PEND_MAX  saturation point of the per-register pending counters, CW width
package wb_pkg;

  localparam int DW       = 8;
  localparam int NREG     = 4;
  localparam int AW       = $clog2(NREG);
  localparam int PEND_MAX = 3;
  localparam int CW       = 2;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h7;
  localparam logic [3:0] OP_LD     = 4'h8;
  localparam logic [3:0] OP_ST     = 4'h9;

  // ALU ops and loads write a register; NOP, store and branch/jump do not.
  function automatic logic op_writes(input logic [3:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_LD);
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    return op == OP_LD;
  endfunction

endpackage

// File: rtl/wb_regfile_sb_if.sv
// wb_regfile_sb_if: decode-side and writeback-side signals of the register
// file. The slave modport is the register file; master is whoever drives
// decode issue/read requests and the DM->WB bundle.
//   issue_*         decode issue of a (possibly writing) instruction
//   use_*/rd_addr_* decode read requests, rd_data_* bypassed read data
//   stall           RAW stall back to decode
//   wb_*            registered DM->WB bundle
//   pending         per-register outstanding-write flags
//   sb_err          sticky scoreboard protocol error
interface wb_regfile_sb_if;
  import wb_pkg::*;

  logic                issue_valid;
  logic                issue_wr;
  logic [AW-1:0]       issue_rd;
  logic                use_a;
  logic                use_b;
  logic [AW-1:0]       rd_addr_a;
  logic [AW-1:0]       rd_addr_b;
  logic [DW-1:0]       rd_data_a;
  logic [DW-1:0]       rd_data_b;
  logic                stall;
  logic                wb_valid;
  logic [3:0]          wb_op;
  logic [AW-1:0]       wb_rd;
  logic [DW-1:0]       wb_alu_data;
  logic [DW-1:0]       wb_mem_data;
  logic [NREG-1:0]     pending;
  logic                sb_err;

  modport slave (
    input  issue_valid, issue_wr, issue_rd, use_a, use_b, rd_addr_a, rd_addr_b,
           wb_valid, wb_op, wb_rd, wb_alu_data, wb_mem_data,
    output rd_data_a, rd_data_b, stall, pending, sb_err
  );

  modport master (
    output issue_valid, issue_wr, issue_rd, use_a, use_b, rd_addr_a, rd_addr_b,
           wb_valid, wb_op, wb_rd, wb_alu_data, wb_mem_data,
    input  rd_data_a, rd_data_b, stall, pending, sb_err
  );

endinterface

// File: rtl/wb_regfile_sb_sb_counter.sv
// sb_counter: one saturating up/down pending-write counter.
//   clk, rst_n  clock, async active-low reset
//   inc, dec    issue / retire strobes for this register
//   cnt         current count (registered)
//   pend        cnt != 0 after this edge (registered from next state)
//   err         sticky: inc at PEND_MAX or dec at 0 (net update only)
module sb_counter
  import wb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          pend,
  output logic          err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(PEND_MAX);

  logic [CW-1:0] cnt_nxt;
  logic          err_nxt;

  // inc and dec together cancel, so saturation checks only see a net move.
  always_comb begin
    cnt_nxt = cnt;
    err_nxt = 1'b0;
    if (inc && !dec) begin
      if (cnt == CNT_MAX) err_nxt = 1'b1;
      else                cnt_nxt = cnt + CW'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) err_nxt = 1'b1;
      else           cnt_nxt = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pend <= 1'b0;
      err  <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      pend <= (cnt_nxt != '0);
      err  <= err | err_nxt;
    end
  end

endmodule

// File: rtl/wb_regfile_sb.sv
// wb_regfile_sb: writeback consumer. Commits the DM->WB bundle into a
// NREG x DW register file, serves two bypassed decode read ports and keeps a
// per-register pending-write scoreboard that generates the RAW stall.
//   clk, rst_n  clock, async active-low reset
//   rf          wb_regfile_sb_if slave (decode + writeback + status)
module wb_regfile_sb
  import wb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  wb_regfile_sb_if.slave rf
);

  logic            wb_commit;
  logic [DW-1:0]   wb_data;
  logic [DW-1:0]   regs [NREG];
  logic [CW-1:0]   cnt  [NREG];
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;
  logic [NREG-1:0] pend;
  logic [NREG-1:0] err;
  logic            haz_a;
  logic            haz_b;
  logic            stall;

  assign wb_commit = rf.wb_valid & op_writes(rf.wb_op);
  assign wb_data   = op_is_load(rf.wb_op) ? rf.wb_mem_data : rf.wb_alu_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wb_commit) begin
      regs[rf.wb_rd] <= wb_data;
    end
  end

  assign rf.rd_data_a = (wb_commit && rf.wb_rd == rf.rd_addr_a) ? wb_data : regs[rf.rd_addr_a];
  assign rf.rd_data_b = (wb_commit && rf.wb_rd == rf.rd_addr_b) ? wb_data : regs[rf.rd_addr_b];

  // A retiring write is visible through the bypass, so only writes beyond
  // the one retiring this cycle still block the reader.
  assign haz_a = rf.use_a & (cnt[rf.rd_addr_a] > CW'(dec[rf.rd_addr_a]));
  assign haz_b = rf.use_b & (cnt[rf.rd_addr_b] > CW'(dec[rf.rd_addr_b]));
  assign stall = haz_a | haz_b;

  // Stall depends only on counters and retirement, never on inc: no loop.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc[r] = rf.issue_valid & rf.issue_wr & ~stall & (rf.issue_rd == AW'(r));
      dec[r] = wb_commit & (rf.wb_rd == AW'(r));
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_sb
    sb_counter u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[g]),
      .dec   (dec[g]),
      .cnt   (cnt[g]),
      .pend  (pend[g]),
      .err   (err[g])
    );
  end

  assign rf.stall   = stall;
  assign rf.pending = pend;
  assign rf.sb_err  = |err;

endmodule

// File: tb/tb_wb_regfile_sb.sv
module tb_wb_regfile_sb;

  localparam int F_RDA  = 0;
  localparam int F_RDB  = 1;
  localparam int F_STL  = 2;
  localparam int F_PEND = 3;
  localparam int F_ERR  = 4;

  typedef struct {
    string      name;
    int         field;
    logic [7:0] exp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  event chk_ev;

  wb_regfile_sb_if rf ();

  wb_regfile_sb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1);
  end

  // Monitor: drains the expectation queue whenever stimulus posts a sample.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        case (e.field)
          F_RDA:   act = rf.rd_data_a;
          F_RDB:   act = rf.rd_data_b;
          F_STL:   act = {7'b0, rf.stall};
          F_PEND:  act = {4'b0, rf.pending};
          default: act = {7'b0, rf.sb_err};
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: actual=%h required=%h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  task automatic chk(input string n, input int f, input logic [7:0] v);
    exp_t e;
    e.name = n; e.field = f; e.exp = v;
    exp_q.push_back(e);
    -> chk_ev;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf.issue_valid = 0; rf.issue_wr = 0; rf.issue_rd = 0;
    rf.use_a = 0; rf.use_b = 0; rf.rd_addr_a = 0; rf.rd_addr_b = 0;
    rf.wb_valid = 0; rf.wb_op = 0; rf.wb_rd = 0; rf.wb_alu_data = 0; rf.wb_mem_data = 0;
  endtask

  task automatic issue(input logic [1:0] rd);
    rf.issue_valid = 1; rf.issue_wr = 1; rf.issue_rd = rd;
  endtask

  task automatic wb(input logic [3:0] op, input logic [1:0] rd, input logic [7:0] alu, input logic [7:0] mem);
    rf.wb_valid = 1; rf.wb_op = op; rf.wb_rd = rd; rf.wb_alu_data = alu; rf.wb_mem_data = mem;
  endtask

  initial begin
    rst_n = 0;
    idle();
    #3;
    chk("rst_pend", F_PEND, 8'h00);
    chk("rst_err",  F_ERR,  8'h00);
    chk("rst_rda",  F_RDA,  8'h00);
    #9 rst_n = 1;
    cycle();

    // ALU write with same-cycle bypass
    issue(2); cycle(); idle();
    chk("alu_pend_issued", F_PEND, 8'h04);
    wb(4'h1, 2, 8'h5A, 8'h00); rf.use_a = 1; rf.rd_addr_a = 2; #1;
    chk("alu_bypass_rda", F_RDA, 8'h5A);
    chk("alu_retire_nostall", F_STL, 8'h00);
    cycle(); idle(); rf.rd_addr_a = 2; #1;
    chk("alu_array_rda", F_RDA, 8'h5A);
    chk("alu_pend_clear", F_PEND, 8'h00);

    // Load data select, store does not write
    issue(1); cycle(); idle();
    wb(4'h8, 1, 8'h11, 8'hC3); rf.rd_addr_b = 1; #1;
    chk("ld_bypass_rdb", F_RDB, 8'hC3);
    cycle(); idle();
    wb(4'h9, 1, 8'hFF, 8'h00); rf.rd_addr_b = 1; #1;
    chk("st_no_bypass_rdb", F_RDB, 8'hC3);
    cycle(); idle(); rf.rd_addr_b = 1; #1;
    chk("st_no_write_rdb", F_RDB, 8'hC3);
    chk("st_no_err", F_ERR, 8'h00);
    chk("ld_pend_clear", F_PEND, 8'h00);

    // RAW stall on port A until R3 retires; blocked issue to R0 is dropped
    issue(3); cycle(); idle();
    rf.use_a = 1; rf.rd_addr_a = 3; issue(0); #1;
    chk("raw_stall_1", F_STL, 8'h01);
    cycle();
    chk("raw_issue_dropped", F_PEND, 8'h08);
    chk("raw_stall_2", F_STL, 8'h01);
    cycle();
    wb(4'h2, 3, 8'h77, 8'h00); #1;
    chk("raw_wb_nostall", F_STL, 8'h00);
    chk("raw_wb_rda", F_RDA, 8'h77);
    cycle(); idle();
    chk("raw_pend_after", F_PEND, 8'h01);
    chk("raw_no_err", F_ERR, 8'h00);

    // Simultaneous issue and retire on R0 (cnt=1)
    issue(0); wb(4'h1, 0, 8'h42, 8'h00); cycle(); idle();
    chk("sim_pend_hold", F_PEND, 8'h01);
    chk("sim_no_err", F_ERR, 8'h00);
    wb(4'h1, 0, 8'h42, 8'h00); cycle(); idle(); rf.rd_addr_a = 0; #1;
    chk("sim_pend_clear", F_PEND, 8'h00);
    chk("sim_r0_rda", F_RDA, 8'h42);

    // Port B, two writes in flight: first retirement still stalls
    issue(3); cycle(); cycle(); idle();
    wb(4'h3, 3, 8'hAB, 8'h00); rf.use_b = 1; rf.rd_addr_b = 3; #1;
    chk("b_cnt2_stall", F_STL, 8'h01);
    cycle();
    chk("b_cnt1_nostall", F_STL, 8'h00);
    chk("b_bypass_rdb", F_RDB, 8'hAB);
    cycle(); idle();
    chk("b_pend_clear", F_PEND, 8'h00);

    // inc&dec at PEND_MAX: hold, no error; then drain
    issue(2); cycle(); cycle(); cycle(); idle();
    chk("max_pend", F_PEND, 8'h04);
    issue(2); wb(4'h1, 2, 8'h10, 8'h00); cycle(); idle();
    chk("max_incdec_no_err", F_ERR, 8'h00);
    chk("max_incdec_pend", F_PEND, 8'h04);
    wb(4'h1, 2, 8'h20, 8'h00); cycle(); cycle();
    chk("max_drain_2", F_PEND, 8'h04);
    cycle(); idle();
    chk("max_drain_3", F_PEND, 8'h00);
    chk("max_drain_no_err", F_ERR, 8'h00);

    // Retire with nothing pending: sticky error, write still lands
    wb(4'h1, 1, 8'h99, 8'h00); #1;
    chk("underflow_pre_err", F_ERR, 8'h00);
    cycle(); idle(); rf.rd_addr_a = 1; #1;
    chk("underflow_err", F_ERR, 8'h01);
    chk("underflow_pend", F_PEND, 8'h00);
    chk("underflow_rda", F_RDA, 8'h99);

    // Four issues to R2: saturate at 3
    issue(2); cycle(); cycle(); cycle(); cycle(); idle();
    chk("sat_pend", F_PEND, 8'h04);
    chk("sat_err_sticky", F_ERR, 8'h01);
    wb(4'h1, 2, 8'h5A, 8'h00); cycle(); cycle();
    chk("sat_drain_2", F_PEND, 8'h04);
    cycle(); idle();
    chk("sat_drain_3", F_PEND, 8'h00);

    // Mid-run reset, no clock edge needed
    issue(0); cycle(); idle(); rf.rd_addr_a = 1; rf.rd_addr_b = 2; #1;
    chk("prerst_rda", F_RDA, 8'h99);
    chk("prerst_rdb", F_RDB, 8'h5A);
    chk("prerst_pend", F_PEND, 8'h01);
    #2 rst_n = 0; #1;
    chk("midrst_rda", F_RDA, 8'h00);
    chk("midrst_rdb", F_RDB, 8'h00);
    chk("midrst_pend", F_PEND, 8'h00);
    chk("midrst_err", F_ERR, 8'h00);
    #3 rst_n = 1;
    #2;

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL undrained: actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
